// File: rtl/obi_lsu_mgr.sv
// OBI manager load/store unit: one outstanding access, byte-lane steering and load extension.
// Optional watchdog enabled by defining OBI_LSU_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module obi_lsu_mgr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        MISAL = 2'd3
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        obi_req_q;
    logic        obi_we_q;
    logic [31:0] obi_addr_q;
    logic [3:0]  obi_be_q;
    logic [31:0] obi_wdata_q;
    logic        lsu_rvalid_q;
    logic        lsu_err_q;
    logic [31:0] lsu_rdata_q;

    logic        illegal_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data_d;

`ifdef OBI_LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] cnt_q;
`endif

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        illegal_d = 1'b0;
        be_d      = 4'b0000;
        wdata_d   = lsu_wdata_i;
        case (lsu_size_i)
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                be_d      = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_d   = {2{lsu_wdata_i[15:0]}};
                illegal_d = lsu_addr_i[0];
            end
            2'b10: begin
                be_d      = 4'b1111;
                illegal_d = (lsu_addr_i[1:0] != 2'b00);
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = obi_rdata_i[7:0];
        case (obi_addr_q[1:0])
            2'b00:   byte_sel = obi_rdata_i[7:0];
            2'b01:   byte_sel = obi_rdata_i[15:8];
            2'b10:   byte_sel = obi_rdata_i[23:16];
            default: byte_sel = obi_rdata_i[31:24];
        endcase
        half_sel = obi_addr_q[1] ? obi_rdata_i[31:16] : obi_rdata_i[15:0];
        case (size_q)
            2'b00:   load_data_d = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_data_d = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_data_d = obi_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            obi_req_q    <= 1'b0;
            obi_we_q     <= 1'b0;
            obi_addr_q   <= 32'h0;
            obi_be_q     <= 4'h0;
            obi_wdata_q  <= 32'h0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= 32'h0;
`ifdef OBI_LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (illegal_d) begin
                            state_q      <= MISAL;
                            lsu_rvalid_q <= 1'b1;
                            lsu_err_q    <= 1'b1;
                            lsu_rdata_q  <= 32'h0;
                        end else begin
                            state_q     <= REQ;
                            obi_req_q   <= 1'b1;
                            obi_we_q    <= lsu_we_i;
                            obi_addr_q  <= lsu_addr_i;
                            obi_be_q    <= be_d;
                            obi_wdata_q <= wdata_d;
                            size_q      <= lsu_size_i;
                            unsigned_q  <= lsu_unsigned_i;
`ifdef OBI_LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (obi_gnt_i) begin
                        state_q   <= RESP;
                        obi_req_q <= 1'b0;
`ifdef OBI_LSU_TIMEOUT_EN
                        cnt_q     <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q      <= IDLE;
                        obi_req_q    <= 1'b0;
                        lsu_rvalid_q <= 1'b1;
                        lsu_err_q    <= 1'b1;
                        lsu_rdata_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                RESP: begin
                    // Stores and bus errors complete with zero data.
                    if (obi_rvalid_i) begin
                        state_q      <= IDLE;
                        lsu_rvalid_q <= 1'b1;
                        lsu_err_q    <= obi_err_i;
                        lsu_rdata_q  <= (obi_err_i || obi_we_q) ? 32'h0 : load_data_d;
`ifdef OBI_LSU_TIMEOUT_EN
                    end else if (cnt_q == CntLast) begin
                        state_q      <= IDLE;
                        lsu_rvalid_q <= 1'b1;
                        lsu_err_q    <= 1'b1;
                        lsu_rdata_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                MISAL:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_err_o    = lsu_err_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign obi_req_o    = obi_req_q;
    assign obi_we_o     = obi_we_q;
    assign obi_addr_o   = obi_addr_q;
    assign obi_be_o     = obi_be_q;
    assign obi_wdata_o  = obi_wdata_q;

endmodule

// File: tb/tb_obi_lsu_mgr.sv
// Self-checking bench for obi_lsu_mgr: byte-addressed memory model acts as the OBI slave
// and as the reference for expected lanes, enables and extended load data.
module tb_obi_lsu_mgr;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int checkCount = 0;
    int errorCount = 0;
    logic [7:0]  memB [0:255];
    logic [31:0] lastExpRdata = 32'h0;

    always #5 clk = ~clk;

    obi_lsu_mgr #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_busy_o     (lsu_busy_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o),
        .obi_req_o      (obi_req_o),
        .obi_gnt_i      (obi_gnt_i),
        .obi_addr_o     (obi_addr_o),
        .obi_we_o       (obi_we_o),
        .obi_be_o       (obi_be_o),
        .obi_wdata_o    (obi_wdata_o),
        .obi_rvalid_i   (obi_rvalid_i),
        .obi_rdata_i    (obi_rdata_i),
        .obi_err_i      (obi_err_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] busWord(input logic [31:0] addr);
        logic [7:0] b;
        b = {addr[7:2], 2'b00};
        return {memB[b + 8'd3], memB[b + 8'd2], memB[b + 8'd1], memB[b]};
    endfunction

    // Caller is positioned just after a falling edge; returns positioned the same way.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int gntDelay, input int rvDelay, input logic errInj);
        int          n;
        int          off;
        logic        legal;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = int'(addr[1:0]);
        legal = (size != 2'b11) && ((off % n) == 0);
        expWdata = 32'h0;
        expBe    = 4'h0;
        for (int i = 0; i < 4; i++) begin
            expBe[i] = legal && (i >= off) && (i < off + n);
            expWdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        end

        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        @(negedge clk);
        lsu_req_i   = 1'b0;
        lsu_wdata_i = $urandom;

        if (!legal) begin
            checkOutput("misal_obi_req", {31'h0, obi_req_o}, 32'h0);
            checkOutput("misal_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
            checkOutput("misal_err", {31'h0, lsu_err_o}, 32'h1);
            checkOutput("misal_rdata", lsu_rdata_o, 32'h0);
            lastExpRdata = 32'h0;
            @(negedge clk);
            checkOutput("misal_busy_after", {31'h0, lsu_busy_o}, 32'h0);
            checkOutput("misal_rvalid_after", {31'h0, lsu_rvalid_o}, 32'h0);
            checkOutput("misal_obi_req_after", {31'h0, obi_req_o}, 32'h0);
            return;
        end

        checkOutput("req_obi_req", {31'h0, obi_req_o}, 32'h1);
        checkOutput("req_busy", {31'h0, lsu_busy_o}, 32'h1);
        checkOutput("req_addr", obi_addr_o, addr);
        checkOutput("req_we", {31'h0, obi_we_o}, {31'h0, we});
        checkOutput("req_be", {28'h0, obi_be_o}, {28'h0, expBe});
        if (we) checkOutput("req_wdata", obi_wdata_o, expWdata);

        for (int d = 0; d < gntDelay; d++) begin
            obi_gnt_i = 1'b0;
            @(negedge clk);
            checkOutput("hold_obi_req", {31'h0, obi_req_o}, 32'h1);
            checkOutput("hold_addr", obi_addr_o, addr);
            checkOutput("hold_be", {28'h0, obi_be_o}, {28'h0, expBe});
        end
        obi_gnt_i = 1'b1;
        @(negedge clk);
        obi_gnt_i = 1'b0;
        checkOutput("resp_obi_req_low", {31'h0, obi_req_o}, 32'h0);
        checkOutput("resp_no_early_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
        repeat (rvDelay) @(negedge clk);

        obi_rvalid_i = 1'b1;
        obi_err_i    = errInj;
        obi_rdata_i  = we ? $urandom : busWord(addr);
        expRdata = 32'h0;
        if (!we && !errInj) begin
            for (int k = 0; k < n; k++) expRdata |= 32'(memB[8'(addr[7:0] + 8'(k))]) << (8 * k);
            if (!uns && n < 4 && expRdata[8*n-1]) expRdata |= ~((32'h1 << (8 * n)) - 32'h1);
        end
        if (we && !errInj) begin
            for (int i = 0; i < 4; i++)
                if (expBe[i]) memB[{addr[7:2], 2'(i)}] = expWdata[8*i +: 8];
        end
        @(negedge clk);
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        obi_rdata_i  = $urandom;
        checkOutput("done_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
        checkOutput("done_err", {31'h0, lsu_err_o}, {31'h0, errInj});
        checkOutput("done_rdata", lsu_rdata_o, expRdata);
        checkOutput("done_busy", {31'h0, lsu_busy_o}, 32'h0);
        lastExpRdata = expRdata;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {25'h0, lsu_busy_o, lsu_rvalid_o, lsu_err_o, obi_req_o, obi_we_o, 2'b00}, 32'h0);
        checkOutput({tag, "_rdata"}, lsu_rdata_o, 32'h0);
        checkOutput({tag, "_addr"}, obi_addr_o, 32'h0);
        checkOutput({tag, "_be"}, {28'h0, obi_be_o}, 32'h0);
        checkOutput({tag, "_wdata"}, obi_wdata_o, 32'h0);
    endtask

    task automatic driveReq(input logic we, input logic [1:0] size, input logic [31:0] addr);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        @(negedge clk);
        lsu_req_i = 1'b0;
    endtask

    initial begin
        int          cycles;
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        for (int i = 0; i < 256; i++) memB[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
        checkOutput("lw_0x10", lsu_rdata_o, 32'hCAFEF00D);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 0, 1'b0);
        checkOutput("lb_0x13", lsu_rdata_o, 32'hFFFFFFA5);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 0, 1'b0);
        checkOutput("lbu_0x13", lsu_rdata_o, 32'h000000A5);
        memB[8'h14] = 8'h34; memB[8'h15] = 8'h12; memB[8'h16] = 8'h01; memB[8'h17] = 8'h80;
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 0, 0, 1'b0);
        checkOutput("lh_0x16", lsu_rdata_o, 32'hFFFF8001);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 0, 0, 1'b0);
        checkOutput("lhu_0x16", lsu_rdata_o, 32'h00008001);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 0, 0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h08, 32'h1234, 0, 0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 0, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 0, 2, 1'b0);

        // A response with nothing outstanding must not produce a completion.
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        obi_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("stray_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
        checkOutput("stray_rdata_held", lsu_rdata_o, lastExpRdata);

        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom,
                          $urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
        end

`ifdef OBI_LSU_TIMEOUT_EN
        driveReq(1'b0, 2'b10, 32'h40);
        cycles = 0;
        while (obi_req_o === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", 32'(cycles), 32'd16);
        checkOutput("timeout_rvalid", {31'h0, lsu_rvalid_o}, 32'h1);
        checkOutput("timeout_err", {31'h0, lsu_err_o}, 32'h1);
        checkOutput("timeout_rdata", lsu_rdata_o, 32'h0);
        obi_rvalid_i = 1'b1;
        @(negedge clk);
        obi_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("late_rvalid_ignored", {31'h0, lsu_rvalid_o}, 32'h0);
        driveReq(1'b1, 2'b10, 32'h44);
        repeat (2) @(negedge clk);
`else
        driveReq(1'b0, 2'b10, 32'h40);
        repeat (20) @(negedge clk);
        checkOutput("nogrant_req_held", {31'h0, obi_req_o}, 32'h1);
        checkOutput("nogrant_no_rvalid", {31'h0, lsu_rvalid_o}, 32'h0);
`endif
        reset = 1'b0;
        #1;
        checkAllZero("midreq_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", {31'h0, lsu_busy_o}, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h52, 32'h0000BEEF, 1, 1, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h52, 32'h0, 0, 0, 1'b0);
        checkOutput("post_reset_lh", lsu_rdata_o, 32'hFFFFBEEF);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
